// File: rtl/rvv_vregfile_grp.sv
// 32 x VLEN vector register file with byte-strobed write
// and a register-group read sequencer (LMUL beats per request).
module rvv_vregfile_grp #(
  parameter int VLEN      = 128,
  parameter bit ZERO_INIT = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  output logic              init_busy,
  input  logic [VLEN/8-1:0] wstrb,
  input  logic [4:0]        waddr,
  input  logic [VLEN-1:0]   wdata,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_lmul,
  input  logic [4:0]        req_vs1,
  input  logic [4:0]        req_vs2,
  output logic              req_err,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [2:0]        rd_idx,
  output logic              rd_last,
  output logic [VLEN-1:0]   rdata1,
  output logic [VLEN-1:0]   rdata2
);

  localparam int NB = VLEN / 8;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_RUN
  } state_e;

  localparam state_e RST_ST = ZERO_INIT ? S_INIT : S_IDLE;

  logic [VLEN-1:0] vregs [32];

  state_e          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [4:0]      vs1_q, vs1_d;
  logic [4:0]      vs2_q, vs2_d;
  logic [1:0]      lmul_q, lmul_d;
  logic            rd_valid_q, rd_valid_d;
  logic [2:0]      rd_idx_q, rd_idx_d;
  logic            rd_last_q, rd_last_d;
  logic [VLEN-1:0] rdata1_q, rdata1_d;
  logic [VLEN-1:0] rdata2_q, rdata2_d;
  logic            req_err_q, req_err_d;

  logic            wr_en;
  logic            ld;
  logic [2:0]      nidx;
  logic [1:0]      nlmul;
  logic [4:0]      na1, na2;
  logic [4:0]      amask;
  logic [VLEN-1:0] byp1, byp2;

  function automatic logic [2:0] last_of(input logic [1:0] l);
    return 3'((4'd1 << l) - 4'd1);
  endfunction

  assign wr_en = (state_q != S_INIT);
  assign amask = 5'((6'd1 << req_lmul) - 6'd1);

  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      vregs[cnt_q] <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (wstrb[b]) vregs[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    vs1_d      = vs1_q;
    vs2_d      = vs2_q;
    lmul_d     = lmul_q;
    rd_valid_d = rd_valid_q;
    rd_idx_d   = rd_idx_q;
    rd_last_d  = rd_last_q;
    rdata1_d   = rdata1_q;
    rdata2_d   = rdata2_q;
    req_err_d  = 1'b0;
    ld         = 1'b0;
    nidx       = rd_idx_q + 3'd1;
    nlmul      = lmul_q;
    na1        = vs1_q + {2'b00, nidx};
    na2        = vs2_q + {2'b00, nidx};

    unique case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (req_valid) begin
          if (|((req_vs1 | req_vs2) & amask)) begin
            req_err_d = 1'b1;
          end else begin
            vs1_d      = req_vs1;
            vs2_d      = req_vs2;
            lmul_d     = req_lmul;
            nlmul      = req_lmul;
            nidx       = 3'd0;
            na1        = req_vs1;
            na2        = req_vs2;
            ld         = 1'b1;
            rd_valid_d = 1'b1;
            state_d    = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (!rd_valid_q || rd_ready) begin
          if (rd_valid_q && rd_last_q) begin
            rd_valid_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            if (!rd_valid_q) begin
              nidx = rd_idx_q;
              na1  = vs1_q + {2'b00, rd_idx_q};
              na2  = vs2_q + {2'b00, rd_idx_q};
            end
            ld         = 1'b1;
            rd_valid_d = 1'b1;
          end
        end
      end
      default: state_d = RST_ST;
    endcase

    // a beat loaded alongside a write to its source sees the merged bytes
    byp1 = vregs[na1];
    byp2 = vregs[na2];
    for (int b = 0; b < NB; b++) begin
      if (wr_en && wstrb[b] && waddr == na1) byp1[8*b +: 8] = wdata[8*b +: 8];
      if (wr_en && wstrb[b] && waddr == na2) byp2[8*b +: 8] = wdata[8*b +: 8];
    end

    if (ld) begin
      rd_idx_d  = nidx;
      rd_last_d = (nidx == last_of(nlmul));
      rdata1_d  = byp1;
      rdata2_d  = byp2;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= RST_ST;
      cnt_q      <= '0;
      vs1_q      <= '0;
      vs2_q      <= '0;
      lmul_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_idx_q   <= '0;
      rd_last_q  <= 1'b0;
      rdata1_q   <= '0;
      rdata2_q   <= '0;
      req_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      vs1_q      <= vs1_d;
      vs2_q      <= vs2_d;
      lmul_q     <= lmul_d;
      rd_valid_q <= rd_valid_d;
      rd_idx_q   <= rd_idx_d;
      rd_last_q  <= rd_last_d;
      rdata1_q   <= rdata1_d;
      rdata2_q   <= rdata2_d;
      req_err_q  <= req_err_d;
    end
  end

  assign init_busy = (state_q == S_INIT);
  assign req_ready = (state_q == S_IDLE);
  assign req_err   = req_err_q;
  assign rd_valid  = rd_valid_q;
  assign rd_idx    = rd_idx_q;
  assign rd_last   = rd_last_q;
  assign rdata1    = rdata1_q;
  assign rdata2    = rdata2_q;

endmodule

// File: tb/tb_rvv_vregfile_grp.sv
// Scoreboard bench for rvv_vregfile_grp at VLEN=32, ZERO_INIT=1.
module tb_rvv_vregfile_grp;

  logic        clk = 1'b0;
  logic        resetn;
  logic        init_busy;
  logic [3:0]  wstrb;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_lmul;
  logic [4:0]  req_vs1;
  logic [4:0]  req_vs2;
  logic        req_err;
  logic        rd_valid;
  logic        rd_ready;
  logic [2:0]  rd_idx;
  logic        rd_last;
  logic [31:0] rdata1;
  logic [31:0] rdata2;

  typedef struct packed {
    logic [2:0]  idx;
    logic        last;
    logic [31:0] d1;
    logic [31:0] d2;
  } beat_t;

  beat_t       sbq[$];
  logic [31:0] mdl [32];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  rvv_vregfile_grp #(.VLEN(32), .ZERO_INIT(1'b1)) dut (
    .clk(clk), .resetn(resetn), .init_busy(init_busy),
    .wstrb(wstrb), .waddr(waddr), .wdata(wdata),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_lmul(req_lmul), .req_vs1(req_vs1), .req_vs2(req_vs2),
    .req_err(req_err), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_idx(rd_idx), .rd_last(rd_last),
    .rdata1(rdata1), .rdata2(rdata2)
  );

  task automatic wr(input logic [4:0] a, input logic [3:0] s,
                    input logic [31:0] d);
    waddr = a; wstrb = s; wdata = d;
    for (int i = 0; i < 4; i++) if (s[i]) mdl[a][8*i +: 8] = d[8*i +: 8];
    @(negedge clk);
    wstrb = 4'h0;
  endtask

  task automatic issue(input logic [4:0] v1, input logic [4:0] v2,
                       input logic [1:0] l, input logic [4:0] wa,
                       input logic [3:0] ws, input logic [31:0] wd);
    beat_t b;
    int n;
    logic [4:0] m;
    req_valid = 1'b1; req_vs1 = v1; req_vs2 = v2; req_lmul = l;
    waddr = wa; wstrb = ws; wdata = wd;
    for (int i = 0; i < 4; i++) if (ws[i]) mdl[wa][8*i +: 8] = wd[8*i +: 8];
    n = 1 << l;
    m = 5'(n - 1);
    if (((v1 | v2) & m) == 5'd0) begin
      for (int i = 0; i < n; i++) begin
        b.idx  = 3'(i);
        b.last = (i == n - 1);
        b.d1   = mdl[v1 + 5'(i)];
        b.d2   = mdl[v2 + 5'(i)];
        sbq.push_back(b);
      end
    end
    @(negedge clk);
    req_valid = 1'b0; wstrb = 4'h0;
  endtask

  task automatic test_reset();
    int n;
    logic bad;
    checks++;
    if ({init_busy, req_ready, req_err, rd_valid, rd_last, rdata1} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0}) begin
      failures++;
      $display("FAIL reset_state got busy=%b rdy=%b err=%b vld=%b req busy=1 others 0",
               init_busy, req_ready, req_err, rd_valid);
    end
    @(negedge clk);
    resetn = 1'b1;
    n = 0; bad = 1'b0;
    while (init_busy && n < 100) begin
      if (req_ready) bad = 1'b1;
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 32 || bad) begin
      failures++;
      $display("FAIL init_len got %0d cycles rdy_seen=%b req 32 cycles rdy_seen=0", n, bad);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_ready got %b req 1", req_ready);
    end
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
  endtask

  task automatic test_single();
    beat_t e;
    int w;
    issue(5'd0, 5'd31, 2'd0, 5'd0, 4'h0, 32'h0);
    w = 0;
    while (!rd_valid && w < 20) begin @(negedge clk); w++; end
    e = sbq.pop_front();
    checks++;
    if ({rd_valid, rd_idx, rd_last, rdata1, rdata2} !==
        {1'b1, e.idx, e.last, e.d1, e.d2} || w != 0) begin
      failures++;
      $display("FAIL single_beat got v=%b i=%0d l=%b %h/%h req i=%0d l=%b %h/%h",
               rd_valid, rd_idx, rd_last, rdata1, rdata2, e.idx, e.last, e.d1, e.d2);
    end
    @(negedge clk);
    checks++;
    if (rd_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_done got vld=%b rdy=%b req 0/1", rd_valid, req_ready);
    end
  endtask

  task automatic test_strobe();
    beat_t e;
    int w;
    wr(5'd4, 4'hf, 32'h01234567);
    wr(5'd4, 4'b0010, 32'hFFFFFFFF);
    issue(5'd4, 5'd4, 2'd0, 5'd0, 4'h0, 32'h0);
    w = 0;
    while (!rd_valid && w < 20) begin @(negedge clk); w++; end
    e = sbq.pop_front();
    checks++;
    if ({rd_valid, rd_idx, rd_last, rdata1, rdata2} !==
        {1'b1, e.idx, e.last, e.d1, e.d2} || rdata1 !== 32'h0123FF67) begin
      failures++;
      $display("FAIL strobe got %h/%h req %h/%h", rdata1, rdata2, e.d1, 32'h0123FF67);
    end
    @(negedge clk);
  endtask

  task automatic test_group();
    beat_t e;
    int w;
    for (int i = 0; i < 4; i++) begin
      wr(5'(8 + i), 4'hf, 32'hA0 + 32'(i));
      wr(5'(12 + i), 4'hf, 32'hB0 + 32'(i));
    end
    rd_ready = 1'b1;
    issue(5'd8, 5'd12, 2'd2, 5'd0, 4'h0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (!rd_valid && w < 20) begin @(negedge clk); w++; end
      e = sbq.pop_front();
      checks++;
      if ({rd_valid, rd_idx, rd_last, rdata1, rdata2} !==
          {1'b1, e.idx, e.last, e.d1, e.d2} || w != 0) begin
        failures++;
        $display("FAIL group_beat%0d got v=%b i=%0d l=%b %h/%h req i=%0d l=%b %h/%h",
                 k, rd_valid, rd_idx, rd_last, rdata1, rdata2,
                 e.idx, e.last, e.d1, e.d2);
      end
      @(negedge clk);
    end
    checks++;
    if (req_ready !== 1'b1 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL group_done got rdy=%b vld=%b req 1/0", req_ready, rd_valid);
    end
  endtask

  task automatic test_stall(input logic [4:0] wa);
    beat_t e;
    int w;
    rd_ready = 1'b1;
    issue(5'd8, 5'd12, 2'd2, 5'd0, 4'h0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (!rd_valid && w < 20) begin @(negedge clk); w++; end
      e = sbq.pop_front();
      checks++;
      if ({rd_valid, rd_idx, rd_last, rdata1, rdata2} !==
          {1'b1, e.idx, e.last, e.d1, e.d2}) begin
        failures++;
        $display("FAIL stall_v%0d_beat%0d got i=%0d %h/%h req i=%0d %h/%h",
                 wa, k, rd_idx, rdata1, rdata2, e.idx, e.d1, e.d2);
      end
      if (k == 1) begin
        rd_ready = 1'b0;
        wr(wa, 4'hf, 32'hDEAD);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rd_idx !== 3'd1 || rdata1 !== e.d1 || rd_valid !== 1'b1) begin
          failures++;
          $display("FAIL stall_hold got i=%0d %h req i=1 %h", rd_idx, rdata1, e.d1);
        end
        if (wa == 5'd10 && sbq.size() > 0) sbq[0].d1 = mdl[10];
        rd_ready = 1'b1;
      end
      @(negedge clk);
    end
    wr(wa, 4'hf, 32'hA0 + 32'(wa - 5'd8));
  endtask

  task automatic test_misalign();
    beat_t e;
    int w;
    issue(5'd6, 5'd5, 2'd1, 5'd0, 4'h0, 32'h0);
    checks++;
    if (req_err !== 1'b1 || rd_valid !== 1'b0 || sbq.size() != 0) begin
      failures++;
      $display("FAIL misalign_err got err=%b vld=%b req 1/0", req_err, rd_valid);
    end
    @(negedge clk);
    checks++;
    if (req_err !== 1'b0 || req_ready !== 1'b1 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL misalign_after got err=%b rdy=%b vld=%b req 0/1/0",
               req_err, req_ready, rd_valid);
    end
    issue(5'd6, 5'd4, 2'd1, 5'd0, 4'h0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      w = 0;
      while (!rd_valid && w < 20) begin @(negedge clk); w++; end
      e = sbq.pop_front();
      checks++;
      if ({rd_valid, rd_idx, rd_last, rdata1, rdata2} !==
          {1'b1, e.idx, e.last, e.d1, e.d2}) begin
        failures++;
        $display("FAIL aligned_beat%0d got i=%0d l=%b %h/%h req i=%0d l=%b %h/%h",
                 k, rd_idx, rd_last, rdata1, rdata2, e.idx, e.last, e.d1, e.d2);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_bypass();
    beat_t e;
    int w;
    issue(5'd8, 5'd12, 2'd0, 5'd8, 4'hf, 32'h55);
    w = 0;
    while (!rd_valid && w < 20) begin @(negedge clk); w++; end
    e = sbq.pop_front();
    checks++;
    if ({rd_valid, rd_idx, rd_last, rdata1, rdata2} !==
        {1'b1, e.idx, e.last, e.d1, e.d2} || rdata1 !== 32'h55) begin
      failures++;
      $display("FAIL bypass got %h/%h req %h/%h", rdata1, rdata2, e.d1, e.d2);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_run();
    beat_t e;
    int n;
    rd_ready = 1'b1;
    issue(5'd8, 5'd12, 2'd2, 5'd0, 4'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rd_idx !== 3'd2 || rd_valid !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset got i=%0d vld=%b req 2/1", rd_idx, rd_valid);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (rd_valid !== 1'b0 || init_busy !== 1'b1 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got vld=%b busy=%b rdy=%b req 0/1/0",
               rd_valid, init_busy, req_ready);
    end
    sbq.delete();
    @(negedge clk);
    resetn = 1'b1;
    n = 0;
    while (init_busy && n < 100) begin n++; @(negedge clk); end
    checks++;
    if (n !== 32) begin
      failures++;
      $display("FAIL reinit_len got %0d req 32", n);
    end
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    issue(5'd0, 5'd8, 2'd3, 5'd0, 4'h0, 32'h0);
    for (int k = 0; k < 8; k++) begin
      e = sbq.pop_front();
      checks++;
      if ({rd_valid, rd_idx, rd_last, rdata1, rdata2} !==
          {1'b1, e.idx, e.last, e.d1, e.d2}) begin
        failures++;
        $display("FAIL cleared_lo%0d got i=%0d %h/%h req i=%0d %h/%h",
                 k, rd_idx, rdata1, rdata2, e.idx, e.d1, e.d2);
      end
      @(negedge clk);
    end
    issue(5'd16, 5'd24, 2'd3, 5'd0, 4'h0, 32'h0);
    for (int k = 0; k < 8; k++) begin
      e = sbq.pop_front();
      checks++;
      if ({rd_valid, rd_idx, rd_last, rdata1, rdata2} !==
          {1'b1, e.idx, e.last, e.d1, e.d2}) begin
        failures++;
        $display("FAIL cleared_hi%0d got i=%0d %h/%h req i=%0d %h/%h",
                 k, rd_idx, rdata1, rdata2, e.idx, e.d1, e.d2);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    resetn = 1'b0; wstrb = 4'h0; waddr = 5'd0; wdata = 32'h0;
    req_valid = 1'b0; req_lmul = 2'd0; req_vs1 = 5'd0; req_vs2 = 5'd0;
    rd_ready = 1'b1;
    #2;
    test_reset();
    test_single();
    test_strobe();
    test_group();
    test_stall(5'd9);
    test_stall(5'd10);
    test_misalign();
    test_bypass();
    test_reset_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
